// File: rtl/aes_mode_chainer.sv
// aes_mode_chainer: block-mode front end for an external AES block core.
// Collects WORDS plaintext words into one block, applies ECB / CBC-encrypt /
// CTR chaining, trades whole blocks with the core over valid/ready, and
// re-serialises each result block MSB word first.
`timescale 1ns/1ps
module aes_mode_chainer #(
    parameter int WORD_WIDTH  = 32,
    parameter int BLOCK_WIDTH = 128,
    parameter int CTR_WIDTH   = 32,
    parameter int CNT_WIDTH   = 16
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   clear_i,
    input  logic [1:0]             mode_i,
    input  logic [BLOCK_WIDTH-1:0] iv_i,
    input  logic                   iv_load_i,
    input  logic                   in_valid_i,
    output logic                   in_ready_o,
    input  logic [WORD_WIDTH-1:0]  in_data_i,
    output logic                   out_valid_o,
    input  logic                   out_ready_i,
    output logic [WORD_WIDTH-1:0]  out_data_o,
    output logic                   core_req_valid_o,
    input  logic                   core_req_ready_i,
    output logic [BLOCK_WIDTH-1:0] core_req_data_o,
    input  logic                   core_rsp_valid_i,
    output logic                   core_rsp_ready_o,
    input  logic [BLOCK_WIDTH-1:0] core_rsp_data_i,
    output logic                   busy_o,
    output logic [CNT_WIDTH-1:0]   blocks_done_o
);

    localparam int WORDS = BLOCK_WIDTH / WORD_WIDTH;
    localparam int IW    = $clog2(WORDS + 1);
    localparam int OW    = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam logic [IW-1:0] FULL = IW'(WORDS);
    localparam logic [OW-1:0] LAST = OW'(WORDS - 1);
    // Bits of the chain register that act as the CTR counter.
    localparam logic [BLOCK_WIDTH-1:0] CTR_MASK = BLOCK_WIDTH'({CTR_WIDTH{1'b1}});

    localparam logic [1:0] M_CBC = 2'd1;
    localparam logic [1:0] M_CTR = 2'd2;

    typedef enum logic [2:0] {
        S_COLLECT,
        S_ISSUE,
        S_WAIT,
        S_EMIT,
        S_DRAIN
    } state_t;

    state_t                 state_q, state_d;
    logic [IW-1:0]          in_cnt_q, in_cnt_d;
    logic [BLOCK_WIDTH-1:0] buf_q, buf_d;
    logic [BLOCK_WIDTH-1:0] pend_q, pend_d;
    logic [BLOCK_WIDTH-1:0] res_q, res_d;
    logic [BLOCK_WIDTH-1:0] chain_q, chain_d;
    logic [1:0]             mode_q, mode_d;
    logic [OW-1:0]          out_idx_q, out_idx_d;
    logic [CNT_WIDTH-1:0]   cnt_q, cnt_d;

    logic [BLOCK_WIDTH-1:0] req_blk;
    logic [CTR_WIDTH-1:0]   ctr_inc;
    logic                   in_acc, out_hs, req_hs, rsp_hs;

    assign in_ready_o       = (in_cnt_q != FULL);
    assign core_req_valid_o = (state_q == S_ISSUE);
    assign core_rsp_ready_o = (state_q == S_WAIT) || (state_q == S_DRAIN);
    assign out_valid_o      = (state_q == S_EMIT);
    // res_q is shifted left as words leave, so the current word is always on top.
    assign out_data_o       = out_valid_o ? res_q[BLOCK_WIDTH-1 -: WORD_WIDTH] : '0;
    assign core_req_data_o  = core_req_valid_o ? req_blk : '0;
    assign busy_o           = (state_q != S_COLLECT) || (in_cnt_q != '0);
    assign blocks_done_o    = cnt_q;

    assign in_acc = in_valid_i && in_ready_o;
    assign out_hs = out_valid_o && out_ready_i;
    assign req_hs = core_req_valid_o && core_req_ready_i;
    assign rsp_hs = core_rsp_valid_i && core_rsp_ready_o;

    assign ctr_inc = chain_q[CTR_WIDTH-1:0] + CTR_WIDTH'(1);

    // Request block; mode_i is live here because it is only latched on acceptance.
    always_comb begin
        req_blk = buf_q;
        case (mode_i)
            M_CBC:   req_blk = buf_q ^ chain_q;
            M_CTR:   req_blk = chain_q;
            default: req_blk = buf_q;
        endcase
    end

    // Next-state logic for the buffer, FSM, chain register and counters.
    always_comb begin
        state_d   = state_q;
        in_cnt_d  = in_cnt_q;
        buf_d     = buf_q;
        pend_d    = pend_q;
        res_d     = res_q;
        chain_d   = chain_q;
        mode_d    = mode_q;
        out_idx_d = out_idx_q;
        cnt_d     = cnt_q;

        // Input fills independently of the FSM so the next block overlaps.
        if (in_acc) begin
            buf_d    = (buf_q << WORD_WIDTH) | BLOCK_WIDTH'(in_data_i);
            in_cnt_d = in_cnt_q + IW'(1);
        end

        case (state_q)
            S_COLLECT: begin
                if (iv_load_i) chain_d = iv_i;
                if (in_cnt_q == FULL) state_d = S_ISSUE;
            end
            S_ISSUE: begin
                if (req_hs) begin
                    pend_d   = buf_q;
                    mode_d   = mode_i;
                    in_cnt_d = '0;
                    state_d  = S_WAIT;
                end
            end
            S_WAIT: begin
                if (rsp_hs) begin
                    res_d = (mode_q == M_CTR) ? (core_rsp_data_i ^ pend_q) : core_rsp_data_i;
                    if (mode_q == M_CBC) chain_d = core_rsp_data_i;
                    else if (mode_q == M_CTR) chain_d = (chain_q & ~CTR_MASK) | BLOCK_WIDTH'(ctr_inc);
                    state_d = S_EMIT;
                end
            end
            S_EMIT: begin
                if (out_hs) begin
                    res_d     = res_q << WORD_WIDTH;
                    out_idx_d = out_idx_q + OW'(1);
                    if (out_idx_q == LAST) begin
                        out_idx_d = '0;
                        cnt_d     = cnt_q + CNT_WIDTH'(1);
                        state_d   = S_COLLECT;
                    end
                end
            end
            S_DRAIN: begin
                if (rsp_hs) state_d = S_COLLECT;
            end
            default: state_d = S_COLLECT;
        endcase

        // Soft clear overrides everything; chain survives, an accepted request is drained.
        if (clear_i) begin
            in_cnt_d  = '0;
            buf_d     = '0;
            out_idx_d = '0;
            cnt_d     = '0;
            chain_d   = chain_q;
            res_d     = res_q;
            case (state_q)
                S_ISSUE: state_d = req_hs ? S_DRAIN : S_COLLECT;
                S_WAIT:  state_d = rsp_hs ? S_COLLECT : S_DRAIN;
                S_DRAIN: state_d = rsp_hs ? S_COLLECT : S_DRAIN;
                default: state_d = S_COLLECT;
            endcase
        end
    end

    // State registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= S_COLLECT;
            in_cnt_q  <= '0;
            buf_q     <= '0;
            pend_q    <= '0;
            res_q     <= '0;
            chain_q   <= '0;
            mode_q    <= '0;
            out_idx_q <= '0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            in_cnt_q  <= in_cnt_d;
            buf_q     <= buf_d;
            pend_q    <= pend_d;
            res_q     <= res_d;
            chain_q   <= chain_d;
            mode_q    <= mode_d;
            out_idx_q <= out_idx_d;
            cnt_q     <= cnt_d;
        end
    end

endmodule

// File: doc/aes_mode_chainer.md
Name: aes_mode_chainer

Overview:
- Parametrised block-mode front end for the AES HWPE datapath.
- Accepts a plaintext word stream and assembles BLOCK_WIDTH-bit blocks.
- Applies ECB, CBC-encrypt or CTR chaining, exchanges whole blocks with an external block-cipher core over valid/ready, and re-serialises the results onto a word output stream.
- Generalises the fixed 32-bit CBC engine to configurable word and counter widths, runtime mode select, IV loading and clear-with-drain.

Parameters:
- WORD_WIDTH, 32: stream word width; must divide BLOCK_WIDTH.
- BLOCK_WIDTH, 128: cipher block width.
- CTR_WIDTH, 32: low bits of the chain register that increment in CTR mode; 1..BLOCK_WIDTH.
- CNT_WIDTH, 16: width of the completed-block counter.
- Derived: WORDS = BLOCK_WIDTH/WORD_WIDTH.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  asynchronous active-high reset
- clear_i  in  1  synchronous soft clear
- mode_i  in  2  0=ECB, 1=CBC, 2=CTR, 3=reserved (treated as ECB)
- iv_i  in  BLOCK_WIDTH  IV / initial counter
- iv_load_i  in  1  load iv_i into the chain register
- in_valid_i  in  1  plaintext word valid
- in_ready_o  out  1  plaintext word ready
- in_data_i  in  WORD_WIDTH  plaintext word, first word of a block = block MSBs
- out_valid_o  out  1  result word valid
- out_ready_i  in  1  result word ready
- out_data_o  out  WORD_WIDTH  result word, MSB word first
- core_req_valid_o  out  1  block request to cipher core
- core_req_ready_i  in  1  core accepts request
- core_req_data_o  out  BLOCK_WIDTH  block to encrypt
- core_rsp_valid_i  in  1  core result valid
- core_rsp_ready_o  out  1  core result accepted
- core_rsp_data_i  in  BLOCK_WIDTH  core result
- busy_o  out  1  state != COLLECT or input buffer non-empty
- blocks_done_o  out  CNT_WIDTH  completed blocks, wraps

Behaviour:
Reset (rst_i=1, asynchronous):
- All registers zero, state COLLECT, chain=0.
- Outputs: in_ready_o=1; all valids, core_rsp_ready_o, busy_o, blocks_done_o and data outputs 0.

Input buffer:
- in_ready_o = (in_cnt != WORDS); it is independent of FSM state, so the next block fills while the current one is in flight or emitting.
- A word is accepted on in_valid_i&&in_ready_o and shifted in from the LSB side; after WORDS words the first word occupies the MSBs.

FSM COLLECT -> ISSUE -> WAIT -> EMIT -> COLLECT, plus DRAIN:
- COLLECT:
  - Go to ISSUE when in_cnt==WORDS.
  - iv_load_i is honoured only in this state (chain<=iv_i, next cycle) and ignored elsewhere.
- ISSUE:
  - core_req_valid_o=1; core_req_data_o is held stable until accepted.
  - Request data: ECB = buf; CBC = buf^chain; CTR = chain.
  - On core_req_ready_i: pend<=buf, mode_q<=mode_i, in_cnt<=0, go to WAIT.
- WAIT:
  - core_rsp_ready_o=1.
  - On core_rsp_valid_i: res<=core_rsp_data_i (ECB/CBC) or core_rsp_data_i^pend (CTR).
  - Chain update: CBC chain<=core_rsp_data_i; CTR chain[CTR_WIDTH-1:0]<=+1 modulo 2^CTR_WIDTH with upper bits unchanged; ECB chain unchanged.
  - Then go to EMIT.
- EMIT:
  - out_valid_o=1, out_data_o = word out_idx of res, MSB first.
  - Data is held while out_valid_o&&!out_ready_i.
  - On the handshake of the last word: blocks_done_o+=1 (wraps), go to COLLECT.
- Latency: the first result word appears 1 cycle after core response acceptance.
- Minimum request-to-request spacing is WORDS+2 cycles plus core latency.
- mode_i is sampled only at request acceptance; changing it at any other time does not affect the in-flight block.

clear_i (synchronous; priority over all other updates except reset):
- Empties the input buffer, zeroes out_idx and blocks_done_o, and deasserts out_valid_o next cycle.
- From COLLECT, ISSUE or EMIT: go to COLLECT. The request is withdrawn only if not yet accepted; a request handshaken in the same cycle as clear_i counts as accepted and leads to DRAIN.
- From WAIT: go to DRAIN. DRAIN holds core_rsp_ready_o=1, discards the response without touching chain, then goes to COLLECT.
- The chain register is preserved across clear_i.

Simultaneous events:
- Input accept during EMIT's last handshake is legal.
- If in_cnt reaches WORDS in that same cycle, COLLECT exits to ISSUE on the following cycle.

Test Plan:
- ECB, real AES-128 core, key 2b7e1516 28aed2a6 abf71588 09cf4f3c, input 6bc1bee2 2e409f96 e93d7e11 7393172a -> output 3ad77bb4 0d7a3660 a89ecaf3 2466ef97, blocks_done_o=1.
- CBC, same key, iv 000102030405060708090a0b0c0d0e0f loaded, two blocks 6bc1bee2.. then ae2d8a57 1e03ac9c 9eb76fac 45af8e51 -> 7649abac 8119b246 cee98e9b 12e9197d then 5086cb9b 507219ee 95db113a 917678b2.
- CTR, same key, iv f0f1f2f3f4f5f6f7f8f9fafbfcfdfeff, two blocks 6bc1bee2.., ae2d8a57.. -> 874d6191 b620e326 1bef6864 990db6ce then 9806f66b 7970fdff 8617187b b9fffdff.
- Counter wrap, identity stub core, CTR_WIDTH=32, iv low word ffffffff, two zero blocks -> second block output low word 00000000, upper 96 bits equal to iv.
- Backpressure: out_ready_i toggled every 7/11 cycles, core stub with random 0-5 cycle request/response stalls, 16 CBC blocks -> out_data_o stable while stalled, all words correct and ordered, next block's input accepted during EMIT.
- clear_i asserted in WAIT -> DRAIN consumes the one stale response, no out_valid_o, blocks_done_o=0; the following CBC block uses the unchanged chain value.
